// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic-array host feeder.
package systolic_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_FEED  = 5'b00010,
        ST_FLUSH = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } feeder_state_e;

    // Consumers on the driver side: one per column, then one per row.
    function automatic int unsigned consumer_count(input int unsigned w, input int unsigned h);
        return w + h;
    endfunction

    function automatic int unsigned mac_count(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/systolic_feeder_counter.sv
// Up-counter with clear and a terminal flag at limit-1; wraps to zero after the terminal count.
module systolic_feeder_counter #(
    parameter int unsigned limit_p = 8,
    parameter int unsigned cnt_w_p = (limit_p > 1) ? $clog2(limit_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [cnt_w_p-1:0] count_o,
    output logic               last_o
);

    assign last_o = (count_o == cnt_w_p'(limit_p - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (up_i) begin
            count_o <= last_o ? '0 : count_o + 1'b1;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Host-side master: streams a buffered operand set to the systolic driver, flushes it,
// then drains the H*W results into a host-readable register file.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned width_p        = 32,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned depth_p        = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(depth_p*(array_width_p+array_height_p))-1:0] wr_addr_i,
    input  logic [width_p-1:0]         wr_data_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [width_p-1:0]         out_data_o,
    output logic                       flush_o,
    input  logic                       res_valid_i,
    input  logic [width_p-1:0]         res_data_i,
    output logic                       yumi_o,
    input  logic [$clog2(array_width_p*array_height_p)-1:0] res_addr_i,
    output logic [width_p-1:0]         res_data_o
);

    localparam int unsigned cons_lp   = consumer_count(array_width_p, array_height_p);
    localparam int unsigned ops_lp    = depth_p * cons_lp;
    localparam int unsigned macs_lp   = mac_count(array_width_p, array_height_p);
    localparam int unsigned op_aw_lp  = (ops_lp > 1) ? $clog2(ops_lp) : 1;
    localparam int unsigned res_aw_lp = (macs_lp > 1) ? $clog2(macs_lp) : 1;

    feeder_state_e state, state_next;

    logic [width_p-1:0]   op_buf  [ops_lp];
    logic [width_p-1:0]   res_reg [macs_lp];
    logic [op_aw_lp-1:0]  addr;
    logic                 addr_last;
    logic [res_aw_lp-1:0] idx;
    logic                 idx_last;
    logic                 launch;
    logic                 xfer;

    assign launch      = en_i & start_i & ((state == ST_IDLE) | (state == ST_DONE));
    assign xfer        = en_i & out_ready_i & (state == ST_FEED);
    // Flush only while the driver reports ready, so it is idle when the request lands.
    assign flush_o     = en_i & out_ready_i & (state == ST_FLUSH);
    assign yumi_o      = en_i & res_valid_i & (state == ST_DRAIN);
    assign busy_o      = (state == ST_FEED) | (state == ST_FLUSH) | (state == ST_DRAIN);
    assign done_o      = (state == ST_DONE);
    assign out_valid_o = (state == ST_FEED);
    assign out_data_o  = op_buf[addr];
    assign res_data_o  = (32'(res_addr_i) < macs_lp) ? res_reg[res_addr_i] : '0;

    systolic_feeder_counter #(.limit_p(ops_lp), .cnt_w_p(op_aw_lp)) addr_cnt (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (launch),
        .up_i     (xfer),
        .count_o  (addr),
        .last_o   (addr_last)
    );

    systolic_feeder_counter #(.limit_p(macs_lp), .cnt_w_p(res_aw_lp)) drain_cnt (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (launch),
        .up_i     (yumi_o),
        .count_o  (idx),
        .last_o   (idx_last)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (launch)              state_next = ST_FEED;
            ST_FEED:          if (xfer && addr_last)   state_next = ST_FLUSH;
            ST_FLUSH:         if (flush_o)             state_next = ST_DRAIN;
            ST_DRAIN:         if (yumi_o && idx_last)  state_next = ST_DONE;
            default:                                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else if (en_i) begin
            state <= state_next;
        end
    end

    // Operand storage is deliberately left unreset; the host reloads it before use.
    always_ff @(posedge clk_i) begin
        if (en_i && wr_en_i && !busy_o && (32'(wr_addr_i) < ops_lp)) begin
            op_buf[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(macs_lp); i++) begin
                res_reg[i] <= '0;
            end
        end else if (yumi_o) begin
            res_reg[idx] <= res_data_i;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with W=H=K=2: operand stream, flush, drain and host readback.
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        reset_n_i, en_i, wr_en_i, start_i, out_ready_i, res_valid_i;
    logic [2:0]  wr_addr_i;
    logic [31:0] wr_data_i, res_data_i, out_data_o, res_data_o;
    logic [1:0]  res_addr_i;
    logic        busy_o, done_o, out_valid_o, flush_o, yumi_o;

    systolic_feeder #(.width_p(32), .array_width_p(2), .array_height_p(2), .depth_p(2)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .en_i       (en_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .flush_o    (flush_o),
        .res_valid_i(res_valid_i),
        .res_data_i (res_data_i),
        .yumi_o     (yumi_o),
        .res_addr_i (res_addr_i),
        .res_data_o (res_data_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          ready_mode = 0;
    int          flush_cnt = 0, flush_cyc = 0;
    int          run_xfers = 0, first_cyc = 0, last_cyc = 0;
    logic [31:0] mbuf [8];
    logic [31:0] exp_op [$];
    logic [31:0] exp_res [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver-side ready pattern: 0 = always ready, 1 = alternating, otherwise never ready.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            step();
            if (ready_mode == 0)      out_ready_i = 1'b1;
            else if (ready_mode == 1) out_ready_i = ~out_ready_i;
            else                      out_ready_i = 1'b0;
        end
    end

    // Monitor: checks every operand transfer, flush and result accept against the queues.
    initial begin
        bit          prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n_i) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                check(out_valid_o == 1'b1, "hold_valid", 32'(out_valid_o), 32'd1);
                check(out_data_o == prev_data, "hold_data", out_data_o, prev_data);
            end
            if (out_valid_o && out_ready_i && en_i) begin
                if (exp_op.size() == 0) begin
                    check(1'b0, "xfer_extra", out_data_o, 32'd0);
                end else begin
                    e = exp_op.pop_front();
                    check(out_data_o == e, "xfer_data", out_data_o, e);
                end
                if (run_xfers == 0) first_cyc = cyc;
                last_cyc = cyc;
                run_xfers++;
            end
            if (flush_o) begin
                check(out_ready_i == 1'b1, "flush_ready", 32'(out_ready_i), 32'd1);
                check(exp_op.size() == 0, "flush_after_feed", 32'(exp_op.size()), 32'd0);
                check(out_valid_o == 1'b0, "flush_valid_low", 32'(out_valid_o), 32'd0);
                flush_cnt++;
                flush_cyc = cyc;
            end
            if (yumi_o) begin
                check(res_valid_i && en_i, "yumi_qual", 32'(res_valid_i), 32'd1);
                if (exp_res.size() == 0) begin
                    check(1'b0, "yumi_extra", res_data_i, 32'd0);
                end else begin
                    e = exp_res.pop_front();
                    check(res_data_i == e, "yumi_data", res_data_i, e);
                end
            end
            if (!en_i) begin
                check(!yumi_o && !flush_o, "en_low_quiet", {30'd0, yumi_o, flush_o}, 32'd0);
            end
            prev_hold = out_valid_o && !(out_ready_i && en_i);
            prev_data = out_data_o;
        end
    end

    task automatic write_op(input logic [2:0] a, input logic [31:0] d, input bit model);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        if (model) mbuf[a] = d;
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic run_start();
        for (int i = 0; i < 8; i++) exp_op.push_back(mbuf[i]);
        run_xfers = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check(busy_o == 1'b1, "start_busy", 32'(busy_o), 32'd1);
        check(done_o == 1'b0, "start_done_clr", 32'(done_o), 32'd0);
    endtask

    task automatic wait_flush(input int base);
        int n = 0;
        while (flush_cnt == base && n < 200) begin
            step();
            n++;
        end
        check(flush_cnt == base + 1, "flush_count", 32'(flush_cnt), 32'(base + 1));
    endtask

    task automatic present_res(input logic [31:0] v, input int gap);
        res_valid_i = 1'b0;
        repeat (gap) step();
        res_valid_i = 1'b1;
        res_data_i  = v;
        exp_res.push_back(v);
        step();
    endtask

    // Keep valid high after the last result; any further yumi shows up as an extra accept.
    task automatic tail_and_check(input logic [31:0] r0, r1, r2, r3);
        logic [31:0] exp_r [4];
        exp_r = '{r0, r1, r2, r3};
        res_valid_i = 1'b1;
        res_data_i  = 32'h99;
        repeat (3) step();
        res_valid_i = 1'b0;
        check(done_o == 1'b1, "run_done", 32'(done_o), 32'd1);
        check(busy_o == 1'b0, "run_not_busy", 32'(busy_o), 32'd0);
        check(exp_res.size() == 0, "res_pending", 32'(exp_res.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            res_addr_i = 2'(i);
            #1;
            check(res_data_o == exp_r[i], "res_readback", res_data_o, exp_r[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fc;
        reset_n_i = 1'b0; en_i = 1'b1; wr_en_i = 1'b0; start_i = 1'b0;
        wr_addr_i = '0; wr_data_i = '0; res_valid_i = 1'b0; res_data_i = '0; res_addr_i = '0;
        repeat (2) step();
        reset_n_i = 1'b1;
        check(busy_o == 1'b0 && done_o == 1'b0 && out_valid_o == 1'b0 && flush_o == 1'b0 && yumi_o == 1'b0,
              "reset_outputs", {27'd0, busy_o, done_o, out_valid_o, flush_o, yumi_o}, 32'd0);
        check(res_data_o == 32'd0, "reset_res", res_data_o, 32'd0);

        for (int i = 0; i < 8; i++) write_op(3'(i), 32'(i + 1), 1'b1);

        // Reset in the middle of a feed.
        ready_mode = 0;
        run_start();
        repeat (3) step();
        check(out_valid_o == 1'b1, "mid_feed_valid", 32'(out_valid_o), 32'd1);
        check(out_data_o == mbuf[3], "mid_feed_data", out_data_o, mbuf[3]);
        reset_n_i = 1'b0;
        repeat (2) step();
        reset_n_i = 1'b1;
        exp_op.delete();
        check(busy_o == 1'b0 && done_o == 1'b0 && out_valid_o == 1'b0 && flush_o == 1'b0 && yumi_o == 1'b0,
              "abort_outputs", {27'd0, busy_o, done_o, out_valid_o, flush_o, yumi_o}, 32'd0);

        // Full-rate stream from address 0, then gapped drain.
        fc = flush_cnt;
        run_start();
        wait_flush(fc);
        check(run_xfers == 8, "stream_xfers", 32'(run_xfers), 32'd8);
        check(last_cyc - first_cyc == 7, "stream_consecutive", 32'(last_cyc - first_cyc), 32'd7);
        check(flush_cyc == last_cyc + 1, "flush_follows", 32'(flush_cyc), 32'(last_cyc + 1));
        present_res(32'd10, 2);
        present_res(32'd20, 0);
        present_res(32'd30, 1);
        present_res(32'd40, 3);
        tail_and_check(32'd10, 32'd20, 32'd30, 32'd40);

        // Backpressure: ready alternates throughout the feed.
        ready_mode = 1;
        fc = flush_cnt;
        run_start();
        wait_flush(fc);
        check(run_xfers == 8, "bp_xfers", 32'(run_xfers), 32'd8);
        present_res(32'd1, 0);
        present_res(32'd2, 1);
        present_res(32'd3, 0);
        present_res(32'd4, 0);
        tail_and_check(32'd1, 32'd2, 32'd3, 32'd4);

        // Write and start while busy must both be ignored.
        fc = flush_cnt;
        run_start();
        step();
        start_i = 1'b1;
        write_op(3'd7, 32'hDEAD, 1'b0);
        start_i = 1'b0;
        wait_flush(fc);
        check(run_xfers == 8, "guard_xfers", 32'(run_xfers), 32'd8);
        present_res(32'd5, 0);
        present_res(32'd6, 0);
        present_res(32'd7, 2);
        present_res(32'd8, 0);
        tail_and_check(32'd5, 32'd6, 32'd7, 32'd8);

        // Enable low during feed and during drain.
        ready_mode = 0;
        fc = flush_cnt;
        run_start();
        step();
        en_i = 1'b0;
        repeat (3) step();
        en_i = 1'b1;
        wait_flush(fc);
        check(run_xfers == 8, "en_xfers", 32'(run_xfers), 32'd8);
        res_valid_i = 1'b1;
        res_data_i  = 32'd11;
        exp_res.push_back(32'd11);
        en_i = 1'b0;
        repeat (3) step();
        check(exp_res.size() == 1, "en_no_accept", 32'(exp_res.size()), 32'd1);
        en_i = 1'b1;
        step();
        present_res(32'd12, 0);
        present_res(32'd13, 1);
        present_res(32'd14, 0);
        tail_and_check(32'd11, 32'd12, 32'd13, 32'd14);
        check(flush_cnt == 4, "total_flushes", 32'(flush_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
